// File: rtl/mux_rr_arbiter.sv
// Four-source round-robin packet arbiter feeding one registered output lane.
// Optional stall watchdog on a locked owner: define MUX_ARB_WATCHDOG_EN.
module mux_rr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req_valid,
    input  logic [3:0]         req_last,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               err
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e             state_q;
    logic [1:0]         owner_q;
    logic [1:0]         last_grant_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_last_q;
    logic [1:0]         sel_q;

    logic [1:0]         rr_idx;
    logic               rr_hit;
    logic [1:0]         gnt_idx;
    logic               gnt_en;
    logic               can_load;
    logic               accept;
    logic               acc_last;
    logic [WIDTH-1:0]   acc_data;

    // Search starts just after the previous winner so every source gets a turn.
    always_comb begin
        logic [1:0] idx;
        rr_idx = last_grant_q;
        rr_hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!rr_hit && req_valid[idx]) begin
                rr_hit = 1'b1;
                rr_idx = idx;
            end
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign gnt_idx  = (state_q == LOCK) ? owner_q : rr_idx;
    assign gnt_en   = (state_q == LOCK) || rr_hit;
    assign accept   = gnt_en && can_load && req_valid[gnt_idx];
    assign acc_last = req_last[gnt_idx];
    assign acc_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];

    assign req_ready = (gnt_en && can_load && !rst) ? (4'b0001 << gnt_idx) : 4'b0000;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;
    assign busy      = (state_q == LOCK);

`ifdef MUX_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] stall_q;
    logic [CW-1:0] stall_d;
    logic          err_q;
    logic          stall_cyc;

    assign stall_d   = stall_q + 1'b1;
    assign stall_cyc = (state_q == LOCK) && !req_valid[owner_q];
    assign err       = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            last_grant_q <= 2'd3;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            sel_q        <= 2'd0;
`ifdef MUX_ARB_WATCHDOG_EN
            stall_q      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
`ifdef MUX_ARB_WATCHDOG_EN
            err_q <= 1'b0;
`endif
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= acc_data;
                out_last_q  <= acc_last;
                sel_q       <= gnt_idx;
`ifdef MUX_ARB_WATCHDOG_EN
                stall_q     <= '0;
`endif
                if (acc_last) begin
                    state_q      <= IDLE;
                    last_grant_q <= gnt_idx;
                end else begin
                    state_q <= LOCK;
                    owner_q <= gnt_idx;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef MUX_ARB_WATCHDOG_EN
            // A silent owner is evicted after TIMEOUT stalled cycles.
            if (stall_cyc) begin
                if (int'(stall_q) == TIMEOUT - 1) begin
                    state_q      <= IDLE;
                    last_grant_q <= owner_q;
                    err_q        <= 1'b1;
                    stall_q      <= '0;
                end else begin
                    stall_q <= stall_d;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed plus randomized bench for mux_rr_arbiter against a packet-level model.
// Covers the MUX_ARB_WATCHDOG_EN build when that macro is defined.
module tb_mux_rr_arbiter;

    localparam int W  = 16;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req_valid;
    logic [3:0]     req_last;
    logic [4*W-1:0] req_data;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     sel;
    logic           busy;
    logic           err;

    mux_rr_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready),
        .sel(sel), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Packet-level model: owner of an open packet (-1 = none), last winner.
    int           m_lg, m_own, m_stall, m_sel;
    bit           m_valid, m_last, m_err;
    logic [W-1:0] m_data;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lg = 3; m_own = -1; m_stall = 0; m_sel = 0;
        m_valid = 0; m_last = 0; m_err = 0; m_data = '0;
    endtask

    function automatic int winner();
        if (m_own >= 0) return m_own;
        for (int k = 1; k <= 4; k++)
            if (req_valid[(m_lg + k) % 4]) return (m_lg + k) % 4;
        return -1;
    endfunction

    task automatic set_lane(int i, logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    // Inputs already applied; check ready, advance model and DUT one edge, check outputs.
    task automatic step();
        int g;
        bit canl, acc;
        logic [3:0] er;
        #1;
        canl = !m_valid || out_ready;
        g = winner();
        er = (g >= 0 && canl) ? 4'(1 << g) : 4'b0;
        check("req_ready", req_ready, er);
        acc = (g >= 0) && canl && req_valid[g];
        m_err = 0;
        if (acc) begin
            m_valid = 1;
            m_data  = req_data[g*W +: W];
            m_last  = req_last[g];
            m_sel   = g;
            m_stall = 0;
            if (req_last[g]) begin m_lg = g; m_own = -1; end
            else m_own = g;
        end else begin
            if (out_ready) m_valid = 0;
`ifdef MUX_ARB_WATCHDOG_EN
            if (m_own >= 0 && !req_valid[m_own]) begin
                m_stall++;
                if (m_stall == TO) begin
                    m_lg = m_own; m_own = -1; m_err = 1; m_stall = 0;
                end
            end
`endif
        end
        @(posedge clk); #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_last", out_last, m_last);
        check("sel", sel, m_sel);
        check("busy", busy, m_own >= 0);
        check("err", err, m_err);
    endtask

    initial begin
        logic [W-1:0] held;
        int exp_sel[5] = '{0, 1, 2, 3, 0};

        rst = 1; req_valid = 4'b1111; req_last = 4'b1111;
        req_data = '0; out_ready = 1;
        model_reset();
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 0;

        // All four requesting single-beat packets: plain rotation.
        for (int i = 0; i < 4; i++) set_lane(i, 16'h1000 + 16'(i));
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_sel", sel, exp_sel[k]);
        end

        // Three-beat packet from requester 2 while 0 and 1 also want the lane.
        req_valid = 4'b0100; req_last = 4'b1011; set_lane(2, 16'hA001);
        step();
        check("pkt_b1", out_data, 16'hA001);
        req_valid = 4'b0111; set_lane(2, 16'hA002);
        step();
        check("pkt_b2", out_data, 16'hA002);
        check("pkt_busy", busy, 1);
        req_last = 4'b1111; set_lane(2, 16'hA003);
        step();
        check("pkt_b3", out_data, 16'hA003);
        check("pkt_sel", sel, 2);
        check("pkt_done", busy, 0);
        req_valid = 4'b1011;
        step();
        check("after_pkt", sel, 3);

        // Downstream stall holds the output beat.
        req_valid = 4'b1111; out_ready = 0;
        held = out_data;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_hold", out_data, held);
        end
        out_ready = 1;
        step();

        // Asynchronous reset in the middle of a packet from requester 1.
        req_valid = 4'b0010; req_last = 4'b0000;
        step();
        check("mid_busy", busy, 1);
        #3; rst = 1; #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_sel", sel, 0);
        check("arst_ready", req_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        req_valid = 4'b1111; req_last = 4'b1111;
        step();
        check("post_rst_win", sel, 0);

        // Requester 1 opens a packet then goes silent.
        req_valid = 4'b0010; req_last = 4'b0000;
        step();
        req_valid = 4'b0100; req_last = 4'b1111;
        for (int k = 0; k < TO; k++) step();
`ifdef MUX_ARB_WATCHDOG_EN
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        step();
        check("wd_regrant", sel, 2);
        check("wd_err_once", err, 0);
`else
        check("hold_err", err, 0);
        check("hold_busy", busy, 1);
        step();
        check("hold_sel", sel, 1);
        check("hold_busy2", busy, 1);
        req_valid = 4'b0010;
        step();
`endif

        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            req_last  = 4'($urandom);
            req_data  = {$urandom, $urandom};
            out_ready = ($urandom % 4) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
